// File: rtl/fifo_spram_arb.sv
// fifo_spram_arb: first-word-fall-through FIFO on a single-port RAM with a
// round-robin arbiter sharing the port between the write buffer and head prefetch.
`default_nettype none

module fifo_spram_arb #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_LOG2  = 14,
  parameter int ALMOST_FULL = (2 ** DEPTH_LOG2) - 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  write_strobe,
  output logic                  write_ready,
  output logic [WIDTH-1:0]      read_data,
  output logic                  data_available,
  input  logic                  read_strobe,
  output logic [DEPTH_LOG2+1:0] level,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           drop_count,
  input  logic                  clear_flags
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 2;
  localparam logic [DEPTH_LOG2:0] RAM_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LW-1:0]       AF_LEVEL = LW'(ALMOST_FULL);

  typedef enum logic {GRANT_READ = 1'b0, GRANT_WRITE = 1'b1} grant_e;

  logic [WIDTH-1:0]      wbuf_q, wbuf_d;
  logic                  wbuf_valid_q, wbuf_valid_d;
  logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
  logic [DEPTH_LOG2-1:0] rd_addr_q, rd_addr_d;
  logic [DEPTH_LOG2:0]   ram_count_q, ram_count_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic                  avail_q, avail_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [15:0]           drop_count_q, drop_count_d;
  logic                  almost_full_q;
  logic [LW-1:0]         level_d;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      ram_rdata_q;

  logic w_push_ok, w_drop, w_pop, w_underflow_evt;
  logic w_wreq, w_rreq, w_wgnt, w_rgnt;

  always_comb begin
    w_push_ok       = write_strobe && !wbuf_valid_q;
    w_drop          = write_strobe && wbuf_valid_q;
    w_pop           = read_strobe && avail_q;
    w_underflow_evt = read_strobe && !avail_q;
    w_wreq = wbuf_valid_q && (ram_count_q != RAM_FULL);
    w_rreq = (ram_count_q != '0) && !rd_inflight_q && (!avail_q || read_strobe);
    // On contention the side that did not win last time gets the port.
    w_wgnt = w_wreq && (!w_rreq || (last_grant_q == GRANT_READ));
    w_rgnt = w_rreq && (!w_wreq || (last_grant_q == GRANT_WRITE));
  end

  always_comb begin
    wbuf_d        = wbuf_q;
    wbuf_valid_d  = wbuf_valid_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    ram_count_d   = ram_count_q;
    rd_inflight_d = 1'b0;
    head_d        = head_q;
    avail_d       = avail_q;
    last_grant_d  = last_grant_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    drop_count_d  = drop_count_q;

    if (w_push_ok) begin
      wbuf_d       = write_data;
      wbuf_valid_d = 1'b1;
    end

    if (w_wgnt) begin
      wbuf_valid_d = 1'b0;
      wr_addr_d    = wr_addr_q + 1'b1;
      ram_count_d  = ram_count_q + 1'b1;
      last_grant_d = GRANT_WRITE;
    end else if (w_rgnt) begin
      rd_addr_d     = rd_addr_q + 1'b1;
      ram_count_d   = ram_count_q - 1'b1;
      rd_inflight_d = 1'b1;
      last_grant_d  = GRANT_READ;
    end

    // A prefetch landing in the same cycle as a pop refills the head directly.
    if (rd_inflight_q) begin
      head_d  = ram_rdata_q;
      avail_d = 1'b1;
    end else if (w_pop) begin
      avail_d = 1'b0;
    end

    if (clear_flags) begin
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      drop_count_d = 16'd0;
    end
    if (w_underflow_evt) begin
      underflow_d = 1'b1;
    end
    if (w_drop) begin
      overflow_d = 1'b1;
      if (clear_flags) begin
        drop_count_d = 16'd1;
      end else if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end

    level_d = LW'(ram_count_d) + LW'(wbuf_valid_d) + LW'(rd_inflight_d) + LW'(avail_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbuf_q        <= '0;
      wbuf_valid_q  <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      ram_count_q   <= '0;
      rd_inflight_q <= 1'b0;
      head_q        <= '0;
      avail_q       <= 1'b0;
      last_grant_q  <= GRANT_READ;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      drop_count_q  <= 16'd0;
      almost_full_q <= 1'b0;
    end else begin
      wbuf_q        <= wbuf_d;
      wbuf_valid_q  <= wbuf_valid_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      ram_count_q   <= ram_count_d;
      rd_inflight_q <= rd_inflight_d;
      head_q        <= head_d;
      avail_q       <= avail_d;
      last_grant_q  <= last_grant_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      drop_count_q  <= drop_count_d;
      almost_full_q <= (level_d >= AF_LEVEL);
    end
  end

  // Single RAM port: grants are mutually exclusive, so one access per cycle.
  always_ff @(posedge clk) begin
    if (w_wgnt) begin
      mem[wr_addr_q] <= wbuf_q;
    end
    if (w_rgnt) begin
      ram_rdata_q <= mem[rd_addr_q];
    end
  end

  assign write_ready    = !wbuf_valid_q;
  assign read_data      = head_q;
  assign data_available = avail_q;
  assign level          = LW'(ram_count_q) + LW'(wbuf_valid_q) + LW'(rd_inflight_q) + LW'(avail_q);
  assign almost_full    = almost_full_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign drop_count     = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_spram_arb.sv
// tb_fifo_spram_arb: randomized scenarios for fifo_spram_arb on a 16-entry RAM,
// checked against an occupancy count and an in-order queue of pushed data.
`default_nettype none

module tb_fifo_spram_arb;

  localparam int W  = 8;
  localparam int DL = 4;
  localparam int CAP = (2 ** DL) + 2;

  logic          clk;
  logic          reset;
  logic [W-1:0]  write_data;
  logic          write_strobe;
  logic          write_ready;
  logic [W-1:0]  read_data;
  logic          data_available;
  logic          read_strobe;
  logic [DL+1:0] level;
  logic          almost_full;
  logic          overflow;
  logic          underflow;
  logic [15:0]   drop_count;
  logic          clear_flags;

  int total = 0;
  int bad   = 0;

  fifo_spram_arb #(.WIDTH(W), .DEPTH_LOG2(DL), .ALMOST_FULL(12)) dut (
    .clk(clk), .reset(reset), .write_data(write_data), .write_strobe(write_strobe),
    .write_ready(write_ready), .read_data(read_data), .data_available(data_available),
    .read_strobe(read_strobe), .level(level), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow), .drop_count(drop_count),
    .clear_flags(clear_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    write_strobe = 1'b0; read_strobe = 1'b0; clear_flags = 1'b0; write_data = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (write_ready) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_avail(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (data_available) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic push1(input logic [W-1:0] d);
    write_data = d; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic pop1();
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (write_ready !== 1'b1)     begin bad++; $display("FAIL reset_write_ready got=%b want=1", write_ready); end
    total++; if (data_available !== 1'b0)  begin bad++; $display("FAIL reset_avail got=%b want=0", data_available); end
    total++; if (level !== '0)             begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (read_data !== '0)         begin bad++; $display("FAIL reset_read_data got=%h want=00", read_data); end
    total++; if (almost_full !== 1'b0)     begin bad++; $display("FAIL reset_almost_full got=%b want=0", almost_full); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {overflow, underflow}); end
    total++; if (drop_count !== 16'd0)     begin bad++; $display("FAIL reset_drop_count got=%0d want=0", drop_count); end
  endtask

  task automatic test_latency();
    push1(8'hA5);
    for (int c = 1; c <= 3; c++) begin
      total++; if (data_available !== 1'b0) begin bad++; $display("FAIL latency_early cycle=%0d got=%b want=0", c, data_available); end
      step();
    end
    total++; if (data_available !== 1'b1) begin bad++; $display("FAIL latency_avail got=%b want=1", data_available); end
    total++; if (read_data !== 8'hA5)     begin bad++; $display("FAIL latency_data got=%h want=a5", read_data); end
    total++; if (level !== 6'd1)          begin bad++; $display("FAIL latency_level got=%0d want=1", level); end
    pop1();
    total++; if (level !== 6'd0)          begin bad++; $display("FAIL latency_pop_level got=%0d want=0", level); end
    total++; if (data_available !== 1'b0) begin bad++; $display("FAIL latency_pop_avail got=%b want=0", data_available); end
  endtask

  task automatic test_stream();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    bit ws, rs;
    while (popped < 1000 && cyc < 20000) begin
      total++;
      if (level !== 6'(pushed - popped)) begin
        bad++; $display("FAIL stream_level cycle=%0d got=%0d want=%0d", cyc, level, pushed - popped);
      end
      ws = (pushed < 1000) && write_ready && ($urandom_range(0, 3) != 0);
      rs = data_available && ($urandom_range(0, 3) != 0);
      if (rs) begin
        total++;
        if (read_data !== 8'(popped % 256)) begin
          bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", popped, read_data, 8'(popped % 256));
        end
      end
      write_data = 8'(pushed % 256);
      write_strobe = ws;
      read_strobe = rs;
      step();
      pushed += int'(ws);
      popped += int'(rs);
      cyc++;
    end
    write_strobe = 1'b0; read_strobe = 1'b0;
    total++; if (popped != 1000) begin bad++; $display("FAIL stream_count got=%0d want=1000", popped); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL stream_flags got=%b want=00", {overflow, underflow}); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL stream_drops got=%0d want=0", drop_count); end
  endtask

  task automatic fill(ref logic [W-1:0] q[$]);
    bit ok;
    logic [W-1:0] d;
    for (int i = 0; i < CAP; i++) begin
      wait_ready(ok);
      total++; if (!ok) begin bad++; $display("FAIL fill_ready_timeout idx=%0d got=0 want=1", i); end
      d = W'($urandom);
      push1(d);
      q.push_back(d);
    end
    repeat (8) step();
  endtask

  task automatic test_fill();
    logic [W-1:0] q[$];
    logic [W-1:0] exp;
    bit ok;
    fill(q);
    total++; if (level !== 6'(CAP))      begin bad++; $display("FAIL fill_level got=%0d want=%0d", level, CAP); end
    total++; if (write_ready !== 1'b0)   begin bad++; $display("FAIL fill_write_ready got=%b want=0", write_ready); end
    total++; if (almost_full !== 1'b1)   begin bad++; $display("FAIL fill_almost_full got=%b want=1", almost_full); end
    push1(8'h77);
    total++; if (overflow !== 1'b1)      begin bad++; $display("FAIL fill_overflow got=%b want=1", overflow); end
    total++; if (drop_count !== 16'd1)   begin bad++; $display("FAIL fill_drop_count got=%0d want=1", drop_count); end
    total++; if (level !== 6'(CAP))      begin bad++; $display("FAIL fill_level_after_drop got=%0d want=%0d", level, CAP); end
    for (int i = 0; i < CAP; i++) begin
      wait_avail(ok);
      total++; if (!ok) begin bad++; $display("FAIL drain_timeout idx=%0d got=0 want=1", i); end
      exp = q.pop_front();
      total++; if (read_data !== exp) begin bad++; $display("FAIL drain_data idx=%0d got=%h want=%h", i, read_data, exp); end
      pop1();
    end
    repeat (4) step();
    total++; if (level !== 6'd0) begin bad++; $display("FAIL drain_level got=%0d want=0", level); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL drain_almost_full got=%b want=0", almost_full); end
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    total++; if ({overflow, drop_count} !== 17'd0) begin bad++; $display("FAIL fill_clear got=%b/%0d want=0/0", overflow, drop_count); end
  endtask

  task automatic test_underflow_clear();
    bit ok;
    pop1();
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b want=1", underflow); end
    total++; if (level !== 6'd0)     begin bad++; $display("FAIL underflow_level got=%0d want=0", level); end
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_clear got=%b want=0", underflow); end
    push1(8'h11);
    push1(8'h22);
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL busy_drop got=%0d want=1", drop_count); end
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL clear_ready_timeout got=0 want=1"); end
    push1(8'h33);
    clear_flags = 1'b1;
    push1(8'h44);
    clear_flags = 1'b0;
    total++; if (overflow !== 1'b1)    begin bad++; $display("FAIL clear_vs_drop_flag got=%b want=1", overflow); end
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL clear_vs_drop_count got=%0d want=1", drop_count); end
    wait_avail(ok);
    total++; if (read_data !== 8'h11) begin bad++; $display("FAIL clear_drain0 got=%h want=11", read_data); end
    pop1();
    wait_avail(ok);
    total++; if (read_data !== 8'h33) begin bad++; $display("FAIL clear_drain1 got=%h want=33", read_data); end
    pop1();
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    step();
    total++; if (level !== 6'd0) begin bad++; $display("FAIL clear_end_level got=%0d want=0", level); end
  endtask

  task automatic test_midstream_reset();
    bit ok;
    for (int i = 0; i < 8; i++) begin
      wait_ready(ok);
      push1(W'($urandom));
    end
    repeat (8) step();
    total++; if (level !== 6'd8) begin bad++; $display("FAIL mid_level8 got=%0d want=8", level); end
    pop1();
    total++; if (level !== 6'd7) begin bad++; $display("FAIL mid_level7 got=%0d want=7", level); end
    #2 reset = 1'b0;
    #1;
    total++; if (level !== 6'd0)          begin bad++; $display("FAIL mid_reset_level got=%0d want=0", level); end
    total++; if (data_available !== 1'b0) begin bad++; $display("FAIL mid_reset_avail got=%b want=0", data_available); end
    total++; if (read_data !== '0)        begin bad++; $display("FAIL mid_reset_data got=%h want=00", read_data); end
    total++; if (write_ready !== 1'b1)    begin bad++; $display("FAIL mid_reset_ready got=%b want=1", write_ready); end
    @(posedge clk); #1 reset = 1'b1;
    step();
    push1(8'h3C);
    for (int c = 1; c <= 3; c++) begin
      total++; if (data_available !== 1'b0) begin bad++; $display("FAIL mid_fresh_early cycle=%0d got=%b want=0", c, data_available); end
      step();
    end
    total++; if (read_data !== 8'h3C || data_available !== 1'b1) begin
      bad++; $display("FAIL mid_fresh_data got=%h/%b want=3c/1", read_data, data_available);
    end
    total++; if (level !== 6'd1) begin bad++; $display("FAIL mid_fresh_level got=%0d want=1", level); end
    pop1();
  endtask

  task automatic test_saturate();
    logic [W-1:0] q[$];
    fill(q);
    write_strobe = 1'b1;
    repeat (65600) step();
    total++; if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count got=%h want=ffff", drop_count); end
    total++; if (overflow !== 1'b1)       begin bad++; $display("FAIL sat_overflow got=%b want=1", overflow); end
    repeat (400) step();
    write_strobe = 1'b0;
    total++; if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", drop_count); end
    total++; if (level !== 6'(CAP))       begin bad++; $display("FAIL sat_level got=%0d want=%0d", level, CAP); end
    total++; if (read_data !== q[0])      begin bad++; $display("FAIL sat_head got=%h want=%h", read_data, q[0]); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_fill();
    test_underflow_clear();
    test_midstream_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_spram_arb.md
# fifo_spram_arb

Parametrised first-word-fall-through FIFO backed by the up5k single-port SPRAM, successor to the fixed 8-bit SPRAM FIFO used between the UART receiver and transmitter. An internal arbiter time-shares the single RAM port, so producers and consumers may strobe in the same cycle without losing data. Overflow and underflow are reported and counted instead of corrupting the queue.

## Interface
- WIDTH, 8: data width in bits, 1..16 (one SPRAM word per entry).
- DEPTH_LOG2, 14: RAM address bits; RAM capacity DEPTH = 2^DEPTH_LOG2, max 14 per SPRAM block.
- ALMOST_FULL, DEPTH-16: `almost_full` threshold on `level`.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; asserted while low, released synchronously to `clk`.
- write_data  in  WIDTH  data sampled with `write_strobe`.
- write_strobe  in  1  one-cycle push request.
- write_ready  out  1  push will be accepted this cycle.
- read_data  out  WIDTH  head entry, valid while `data_available`.
- data_available  out  1  head entry present.
- read_strobe  in  1  one-cycle pop of head entry.
- level  out  DEPTH_LOG2+2  total entries held (RAM + write buffer + head register).
- almost_full  out  1  `level >= ALMOST_FULL`.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop arrived with no data.
- drop_count  out  16  dropped pushes, saturates at 16'hFFFF.
- clear_flags  in  1  clears `overflow`, `underflow`, `drop_count`.

## Operation
- Storage: write buffer `wbuf` (1 entry), RAM (DEPTH entries), head register `head` (1 entry). Total capacity DEPTH+2.
- Pointers `wr_addr` and `rd_addr` are DEPTH_LOG2 bits and wrap modulo DEPTH. `ram_count` ranges 0..DEPTH.
- `write_ready = !wbuf_valid`.
- A push with `write_ready` loads `wbuf`. A push without it is dropped: `overflow` goes to 1, and `drop_count` increments unless saturated.
- Write request: `wbuf_valid && ram_count < DEPTH`.
- Read request: `ram_count > 0 && !rd_inflight && (!data_available || read_strobe)`.
- Arbiter: at most one RAM access per cycle.
  - A sole requester is granted.
  - When both request, the grant goes to the opposite of `last_grant`. `last_grant` resets to READ, so the first contention grants WRITE.
- Write grant: RAM[wr_addr] <= wbuf; `wr_addr++`; `ram_count++`; `wbuf_valid` clears. A new push in the same cycle is not accepted, because `write_ready` was low.
- Read grant: address `rd_addr`; `rd_addr++`; `ram_count--`; `rd_inflight` set. The next cycle, RAM output loads `head`, `data_available` goes to 1, and `rd_inflight` clears.
- A pop with `data_available` consumes `head`. If no load arrives that cycle, `data_available` drops. A pop with `!data_available` is ignored and sets `underflow`.
- `level` = `ram_count + wbuf_valid + rd_inflight + data_available`, updated every cycle.
- Simultaneous `clear_flags` and a drop or underflow event: the event wins, so the flag is 1 and `drop_count` is 1.
- Reset (asynchronous, any time) clears:
  - `wbuf_valid`, `rd_inflight`, `data_available`, pointers, `ram_count`, `level`, flags, `drop_count`;
  - `read_data` to 0, `almost_full` to 0, `write_ready` to 1 on the first cycle after release.
  - RAM contents are not cleared and are unobservable.

## Timing
- Push to `data_available`, empty FIFO, no contention:
  - push in cycle 0;
  - write grant in cycle 1;
  - read grant in cycle 2;
  - `head` loaded at the end of cycle 3;
  - `data_available` high in cycle 4.
- Sustained throughput:
  - one push per 2 cycles (`wbuf` refill after write grant);
  - one pop per 2 cycles (read in flight blocks the next read);
  - under contention the RAM port alternates W/R.
- Full: with `ram_count == DEPTH` and `wbuf` occupied, `write_ready` stays 0 until a read grant frees a slot. The write is granted the following cycle.
- `read_data` is stable while `data_available` is high and there is no pop.

## Test plan
- Reset then one push of 8'hA5 at cycle 0 -> `data_available` = 1 and `read_data` = 8'hA5 at cycle 4; `level` = 1; after the pop, `level` = 0 and `data_available` = 0.
- Push 1000 bytes 0..999 mod 256, one every 2 cycles, while popping whenever available -> output sequence identical, no flags set, `drop_count` = 0.
- DEPTH_LOG2 = 4: push 18 entries -> `level` = 18, `write_ready` = 0; 19th push -> `overflow` = 1, `drop_count` = 1; drain 18 entries in order; `wr_addr`/`rd_addr` wrapped without corruption.
- Pop on empty after reset -> `underflow` = 1, `level` = 0; `clear_flags` pulse -> `underflow` = 0; `clear_flags` coincident with a dropped push -> `overflow` = 1, `drop_count` = 1.
- Assert `reset` low mid-stream with `level` = 7 and a read in flight -> all outputs at reset values immediately; after release, a fresh push appears at cycle 4 with no stale data.
- Saturate: 70000 dropped pushes -> `drop_count` = 16'hFFFF, still 16'hFFFF after more drops.
